// File: rtl/hazard_unit.sv
// hazard_unit: shift-register scoreboard of in-flight destinations that
// drives per-source bypass selects, load-use stalls and a stall counter.
module hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic                      ext_stall,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  bypass_sel,
    output logic [15:0]               stall_count
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } sb_ent_t;

    sb_ent_t            r_sb [1:DEPTH];
    logic [15:0]        r_cnt;

    sb_ent_t            w_ins;
    logic [REG_AW-1:0]  w_rs  [NUM_SRC];
    logic [SEL_W-1:0]   w_sel [NUM_SRC];
    logic [NUM_SRC-1:0] w_hz;
    logic               w_stall;
    logic               w_cnt_en;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            w_rs[s]  = id_rs[s*REG_AW +: REG_AW];
            w_sel[s] = '0;
            w_hz[s]  = 1'b0;
            if (id_rs_used[s] && (w_rs[s] != '0)) begin
                // walk oldest to youngest so the youngest match wins
                for (int k = DEPTH; k >= 1; k--) begin
                    if (r_sb[k].vld && (r_sb[k].rd == w_rs[s])) begin
                        w_sel[s] = SEL_W'(k);
                        w_hz[s]  = r_sb[k].ld && (k < LOAD_LAT);
                    end
                end
            end
        end
    end

    assign w_stall = id_valid && (|w_hz);
    assign stall   = w_stall;

    always_comb begin
        bypass_sel = '0;
        if (id_valid && !w_stall) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                bypass_sel[s*SEL_W +: SEL_W] = w_sel[s];
            end
        end
    end

    always_comb begin
        w_ins = '0;
        if (id_valid && !w_stall && id_we && (id_rd != '0)) begin
            w_ins = {1'b1, id_rd, id_is_load};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_sb[k].vld <= 1'b0;
            end
        end else if (!ext_stall) begin
            r_sb[1] <= w_ins;
            for (int k = 1; k < DEPTH; k++) begin
                r_sb[k+1] <= r_sb[k];
            end
        end
    end

    assign w_cnt_en = w_stall && !ext_stall && !flush
                   && (r_cnt != 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios then random traffic, all checked
// against a queue-based in-flight instruction model.
module tb_hazard_unit;

    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_is_load;
    logic        ext_stall;
    logic        flush;
    logic        stall;
    logic [3:0]  bypass_sel;
    logic [15:0] stall_count;

    hazard_unit #(
        .REG_AW   (5),
        .NUM_SRC  (2),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .ext_stall   (ext_stall),
        .flush       (flush),
        .stall       (stall),
        .bypass_sel  (bypass_sel),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       w;
        bit [4:0] rd;
        bit       ld;
    } ent_t;

    ent_t        q[$];
    int          m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          e_st;
    int          e_s0;
    int          e_s1;
    logic [31:0] o_st;
    logic [31:0] o_s0;
    logic [31:0] o_s1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Element 0 of q is the youngest in-flight instruction (age 1).
    function automatic void mdl_eval();
        bit [4:0] rs [2];
        int       sel [2];
        bit       hz;
        rs[0] = id_rs[4:0];
        rs[1] = id_rs[9:5];
        hz    = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel[s] = 0;
            if (id_rs_used[s] && rs[s] != 0) begin
                for (int k = 0; k < q.size(); k++) begin
                    if (q[k].w && q[k].rd == rs[s]) begin
                        if (q[k].ld && (k + 1) < LOAD_LAT) hz = 1'b1;
                        else sel[s] = k + 1;
                        break;
                    end
                end
            end
        end
        e_st = id_valid && hz;
        e_s0 = (e_st || !id_valid) ? 0 : sel[0];
        e_s1 = (e_st || !id_valid) ? 0 : sel[1];
    endfunction

    function automatic void mdl_tick();
        ent_t e;
        if (e_st && !ext_stall && !flush && m_cnt < 65535) m_cnt++;
        if (flush) begin
            foreach (q[k]) q[k].w = 1'b0;
        end else if (!ext_stall) begin
            e.w  = id_valid && !e_st && id_we && (id_rd != 0);
            e.rd = id_rd;
            e.ld = id_is_load;
            q.push_front(e);
            if (q.size() > DEPTH) void'(q.pop_back());
        end
    endfunction

    task automatic drv(bit v, int r0, int r1, bit [1:0] u,
                       int rd, bit we, bit ld);
        id_valid   = v;
        id_rs      = {r1[4:0], r0[4:0]};
        id_rs_used = u;
        id_rd      = rd[4:0];
        id_we      = we;
        id_is_load = ld;
    endtask

    task automatic step();
        @(negedge clk);
        mdl_eval();
        o_st = 32'(stall);
        o_s0 = 32'(bypass_sel[1:0]);
        o_s1 = 32'(bypass_sel[3:2]);
        chk("stall", o_st, 32'(e_st));
        chk("sel0", o_s0, e_s0);
        chk("sel1", o_s1, e_s1);
        chk("count", 32'(stall_count), m_cnt);
        @(posedge clk);
        mdl_tick();
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ext_stall = 1'b0;
        flush     = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        q.delete();
        m_cnt = 0;
        #12;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sel", 32'(bypass_sel), 0);
        chk("rst_cnt", 32'(stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU chain on x5
        drv(1, 0, 0, 0, 5, 1, 0); step();
        for (int i = 1; i <= 4; i++) begin
            drv(1, 5, 0, 2'b01, 0, 0, 0); step();
            chk($sformatf("alu_sel_%0d", i), o_s0, (i < 4) ? i : 0);
            chk($sformatf("alu_st_%0d", i), o_st, 0);
        end

        // load-use on x7 via rs2
        drv(1, 0, 0, 0, 7, 1, 1); step();
        drv(1, 0, 7, 2'b10, 0, 0, 0); step();
        chk("lu_stall", o_st, 1);
        chk("lu_cnt", 32'(stall_count), 1);
        step();
        chk("lu_go", o_st, 0);
        chk("lu_sel", o_s1, 2);

        // youngest wins: ALU in stage 1 and stage 3
        drv(1, 0, 0, 0, 3, 1, 0); step();
        drv(1, 0, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 3, 1, 0); step();
        drv(1, 3, 0, 2'b01, 0, 0, 0); step();
        chk("yw_sel", o_s0, 1);

        // youngest is a load: stall despite older match
        drv(1, 0, 0, 0, 3, 1, 0); step();
        drv(1, 0, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 3, 1, 1); step();
        drv(1, 3, 0, 2'b01, 0, 0, 0); step();
        chk("ywl_stall", o_st, 1);
        step();
        chk("ywl_sel", o_s0, 2);

        // x0 destination and unused sources
        drv(1, 0, 0, 0, 0, 1, 1); step();
        drv(1, 0, 0, 2'b11, 0, 0, 0); step();
        chk("x0_stall", o_st, 0);
        chk("x0_sel", o_s0, 0);
        drv(1, 0, 0, 0, 9, 1, 1); step();
        drv(1, 9, 9, 2'b00, 0, 0, 0); step();
        chk("unused_stall", o_st, 0);
        chk("unused_sel", o_s1, 0);

        // same register on both sources
        drv(1, 0, 0, 0, 6, 1, 0); step();
        drv(1, 6, 6, 2'b11, 0, 0, 0); step();
        chk("dual_s0", o_s0, 1);
        chk("dual_s1", o_s1, 1);

        // hazard under ext_stall: stall held, counter frozen
        drv(1, 0, 0, 0, 7, 1, 1); step();
        drv(1, 7, 0, 2'b01, 0, 0, 0);
        ext_stall = 1'b1;
        step();
        chk("xh_st_a", o_st, 1);
        step();
        chk("xh_st_b", o_st, 1);
        chk("xh_cnt", 32'(stall_count), 2);
        ext_stall = 1'b0;
        step();
        chk("xh_st_c", o_st, 1);
        chk("xh_cnt2", 32'(stall_count), 3);
        step();
        chk("xh_sel", o_s0, 2);

        // freeze holds an ALU producer, then flush
        drv(1, 0, 0, 0, 4, 1, 0); step();
        drv(1, 4, 0, 2'b01, 0, 0, 0);
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("frz_sel_%0d", i), o_s0, 1);
        end
        chk("frz_cnt", 32'(stall_count), 3);
        ext_stall = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("fl_sel", o_s0, 0);

        // flush together with ext_stall
        drv(1, 0, 0, 0, 4, 1, 0); step();
        drv(1, 4, 0, 2'b01, 0, 0, 0);
        ext_stall = 1'b1;
        flush     = 1'b1;
        step();
        ext_stall = 1'b0;
        flush     = 1'b0;
        step();
        chk("flx_sel", o_s0, 0);

        // asynchronous reset in the middle of a load-use stall
        drv(1, 0, 0, 0, 5, 1, 1); step();
        drv(1, 5, 0, 2'b01, 0, 0, 0);
        #2;
        chk("ar_pre", 32'(stall), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_stall", 32'(stall), 0);
        chk("ar_sel", 32'(bypass_sel), 0);
        chk("ar_cnt", 32'(stall_count), 0);
        q.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        step();
        chk("ar_post_sel", o_s0, 0);

        // random traffic on a small register set
        for (int i = 0; i < 600; i++) begin
            drv($urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom_range(0, 3)), $urandom_range(0, 3),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            ext_stall = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
